// File: rtl/valu_pkg.sv
// Shared definitions for the vector ALU arbiter: opcodes, FSM states,
// default geometry and the EXEC-length helper.
package valu_pkg;

    localparam int unsigned LANES_DEFAULT = 8;
    localparam int unsigned WIDTH_DEFAULT = 32;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;

    // Wide enough for the largest multiply latency (7).
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } valu_state_e;

    // Number of EXEC cycles for an opcode; an out-of-range multiply latency
    // falls back to a single cycle so the counter never starts at zero.
    function automatic logic [CNT_W-1:0] exec_cycles(input logic [2:0]  op,
                                                     input int unsigned mul_lat);
        logic [CNT_W-1:0] n;
        n = CNT_W'(1);
        if (op == OP_MUL && mul_lat >= 1 && mul_lat <= 7) begin
            n = CNT_W'(mul_lat);
        end
        return n;
    endfunction

endpackage

// File: rtl/vector_alu_arbiter_alu.sv
// Combinational lane-parallel vector ALU. Arithmetic wraps modulo 2^WIDTH;
// conditional subtract returns A unchanged in lanes where A < B (signed).
module vector_alu_arbiter_alu
    import valu_pkg::*;
#(
    parameter int unsigned LANES = LANES_DEFAULT,
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [2:0]             op_i,
    input  logic                   vcsub_i,
    input  logic [LANES*WIDTH-1:0] a_i,
    input  logic [LANES*WIDTH-1:0] b_i,
    output logic [LANES*WIDTH-1:0] y_o
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] y;
        logic             a_lt_b;

        assign a      = a_i[l*WIDTH +: WIDTH];
        assign b      = b_i[l*WIDTH +: WIDTH];
        assign a_lt_b = $signed(a) < $signed(b);

        // Per-lane operation select; product keeps the low WIDTH bits.
        always_comb begin
            y = a;
            case (op_i)
                OP_ADD:  y = a + b;
                OP_SUB:  y = (vcsub_i && a_lt_b) ? a : a - b;
                OP_MUL:  y = a * b;
                OP_AND:  y = a & b;
                OP_OR:   y = a | b;
                OP_XOR:  y = a ^ b;
                default: y = a;
            endcase
        end

        assign y_o[l*WIDTH +: WIDTH] = y;
    end

endmodule

// File: rtl/vector_alu_arbiter.sv
// Two-requester arbiter in front of one shared vector ALU, one operation in
// flight: IDLE -> EXEC (1 or MUL_LAT cycles) -> RESP -> IDLE.
// Define VALU_FIXED_PRIORITY_EN to make requester 0 always win simultaneous
// requests (no round-robin pointer); otherwise grants alternate.
module vector_alu_arbiter
    import valu_pkg::*;
#(
    parameter int unsigned LANES   = LANES_DEFAULT,
    parameter int unsigned WIDTH   = WIDTH_DEFAULT,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    input  logic                   req1_valid,
    output logic                   req0_ready,
    output logic                   req1_ready,
    input  logic [2:0]             req0_op,
    input  logic [2:0]             req1_op,
    input  logic                   req0_vcsub,
    input  logic                   req1_vcsub,
    input  logic [LANES*WIDTH-1:0] req0_a,
    input  logic [LANES*WIDTH-1:0] req0_b,
    input  logic [LANES*WIDTH-1:0] req1_a,
    input  logic [LANES*WIDTH-1:0] req1_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic                   resp_id,
    output logic [LANES*WIDTH-1:0] resp_data,
    output logic                   busy
);

    localparam int unsigned DW = LANES * WIDTH;

    valu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             vcsub_q, vcsub_d;
    logic [DW-1:0]    a_q, a_d;
    logic [DW-1:0]    b_q, b_d;
    logic [DW-1:0]    data_q, data_d;
    logic             id_q, id_d;
    logic             gnt0, gnt1;
    logic [DW-1:0]    alu_y;
`ifndef VALU_FIXED_PRIORITY_EN
    logic             last_q, last_d;
`endif

    // Grant decision: only in IDLE and never while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == StIdle && rst_n) begin
`ifdef VALU_FIXED_PRIORITY_EN
            if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
`else
            if (req0_valid && req1_valid) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
`endif
        end
    end

    // Next-state: latch the winner's operands on grant, count down EXEC,
    // capture the ALU result on the last EXEC cycle, hold it until taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        vcsub_d = vcsub_q;
        a_d     = a_q;
        b_d     = b_q;
        data_d  = data_q;
        id_d    = id_q;
`ifndef VALU_FIXED_PRIORITY_EN
        last_d  = last_q;
`endif
        case (state_q)
            StIdle: begin
                if (gnt0 || gnt1) begin
                    state_d = StExec;
                    op_d    = gnt1 ? req1_op    : req0_op;
                    vcsub_d = gnt1 ? req1_vcsub : req0_vcsub;
                    a_d     = gnt1 ? req1_a     : req0_a;
                    b_d     = gnt1 ? req1_b     : req0_b;
                    id_d    = gnt1;
                    cnt_d   = exec_cycles(op_d, MUL_LAT);
`ifndef VALU_FIXED_PRIORITY_EN
                    last_d  = gnt1;
`endif
                end
            end
            StExec: begin
                if (cnt_q <= CNT_W'(1)) begin
                    data_d  = alu_y;
                    cnt_d   = '0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            vcsub_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            id_q    <= 1'b0;
`ifndef VALU_FIXED_PRIORITY_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            vcsub_q <= vcsub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            id_q    <= id_d;
`ifndef VALU_FIXED_PRIORITY_EN
            last_q  <= last_d;
`endif
        end
    end

    // The ALU sees only the latched operands, so requester inputs may change
    // freely once granted.
    vector_alu_arbiter_alu #(
        .LANES (LANES),
        .WIDTH (WIDTH)
    ) u_alu (
        .op_i    (op_q),
        .vcsub_i (vcsub_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .y_o     (alu_y)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign resp_valid = (state_q == StResp);
    assign resp_id    = id_q;
    assign resp_data  = data_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_vector_alu_arbiter.sv
// Self-checking bench for vector_alu_arbiter: directed vector table,
// multi-cycle corner sequences and randomized traffic against a lane model.
module tb_vector_alu_arbiter;

    localparam int unsigned LANES   = 8;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned DW      = LANES * WIDTH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [2:0]    req0_op, req1_op;
    logic          req0_vcsub, req1_vcsub;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          resp_valid, resp_ready, resp_id, busy;
    logic [DW-1:0] resp_data;

    int n_tests = 0;
    int n_fail  = 0;
    int last_model = 1;

    always #5 clk = ~clk;

    vector_alu_arbiter #(
        .LANES   (LANES),
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .req0_vcsub (req0_vcsub),
        .req1_vcsub (req1_vcsub),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    typedef struct {
        logic [2:0]    op;
        logic          vc;
        int            rid;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp;
        int            lat;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference lane arithmetic in 64-bit integers, reduced modulo 2^32.
    function automatic logic [DW-1:0] ref_vec(input logic [2:0] op, input logic vc,
                                              input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] res;
        logic [WIDTH-1:0] la, lb;
        longint ua, ub, sa, sb, r;
        res = '0;
        for (int l = 0; l < LANES; l++) begin
            la = a[l*WIDTH +: WIDTH];
            lb = b[l*WIDTH +: WIDTH];
            ua = longint'(la);
            ub = longint'(lb);
            sa = (ua >= 64'sh8000_0000) ? ua - 64'sh1_0000_0000 : ua;
            sb = (ub >= 64'sh8000_0000) ? ub - 64'sh1_0000_0000 : ub;
            case (op)
                3'd0:    r = ua + ub;
                3'd1:    r = (vc && sa < sb) ? ua : ua - ub;
                3'd2:    r = ua * ub;
                default: r = 0;
            endcase
            r = r & 64'sh0000_0000_FFFF_FFFF;
            res[l*WIDTH +: WIDTH] = WIDTH'(r);
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] v;
        for (int l = 0; l < LANES; l++) v[l*WIDTH +: WIDTH] = $urandom;
        return v;
    endfunction

    // Arbitration rule: round-robin (or fixed priority) when both request.
    function automatic int pick(input bit v0, input bit v1);
        if (v0 && v1) begin
`ifdef VALU_FIXED_PRIORITY_EN
            return 0;
`else
            return (last_model == 1) ? 0 : 1;
`endif
        end
        return v0 ? 0 : 1;
    endfunction

    task automatic drive(input int r, input logic [2:0] op, input logic vc,
                         input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (r == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_vcsub = vc; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_vcsub = vc; req1_a = a; req1_b = b;
        end
    endtask

    // One operation: check grant, latency, result, hold behaviour, handshake.
    // Called at posedge+1 with request inputs already driven.
    task automatic txn(input int exp_id, input logic [DW-1:0] exp_data, input int exp_lat,
                       input int hold, input bit keep_valid);
        int lat;
        logic [DW-1:0] snap;
        last_model = exp_id;
        #1;
        check("ready0_grant", DW'(req0_ready), DW'(exp_id == 0));
        check("ready1_grant", DW'(req1_ready), DW'(exp_id == 1));
        @(posedge clk); #1;
        if (!keep_valid) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            req0_a = rand_vec(); req0_b = rand_vec(); req0_op = 3'(($urandom));
            req1_a = rand_vec(); req1_b = rand_vec(); req1_op = 3'(($urandom));
            req0_vcsub = ~req0_vcsub; req1_vcsub = ~req1_vcsub;
        end
        lat = 1;
        while (!resp_valid && lat < 20) begin
            check("ready_low_exec", DW'({req0_ready, req1_ready}), '0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", DW'(lat), DW'(exp_lat + 1));
        check("resp_id", DW'(resp_id), DW'(exp_id));
        check("resp_data", resp_data, exp_data);
        snap = resp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", DW'(resp_valid), DW'(1));
            check("hold_data", resp_data, snap);
            check("hold_ready_low", DW'({req0_ready, req1_ready}), '0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("post_hs_valid", DW'(resp_valid), '0);
        check("post_hs_busy", DW'(busy), '0);
    endtask

    initial begin
        logic [DW-1:0] va, vb, e0, e1, e2;
        logic [2:0] op0, op1;
        logic vc0, vc1;
        int id;

        rst_n = 1'b0; resp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = '0; req1_op = '0; req0_vcsub = 1'b0; req1_vcsub = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        #3;
        check("rst_busy", DW'(busy), '0);
        check("rst_resp_valid", DW'(resp_valid), '0);
        check("rst_ready", DW'({req0_ready, req1_ready}), '0);
        check("rst_resp_id", DW'(resp_id), '0);
        check("rst_resp_data", resp_data, '0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        for (int l = 0; l < LANES; l++) begin
            va[l*WIDTH +: WIDTH] = WIDTH'(100 + l);
            vb[l*WIDTH +: WIDTH] = WIDTH'(103);
            e0[l*WIDTH +: WIDTH] = WIDTH'((100 + l) * 103);
            e1[l*WIDTH +: WIDTH] = WIDTH'(l - 3);
            e2[l*WIDTH +: WIDTH] = (l < 3) ? WIDTH'(100 + l) : WIDTH'(l - 3);
        end
        tbl[0] = '{3'b010, 1'b0, 0, va, vb, e0, MUL_LAT};
        tbl[1] = '{3'b001, 1'b0, 1, va, vb, e1, 1};
        tbl[2] = '{3'b001, 1'b1, 0, va, vb, e2, 1};
        for (int l = 0; l < LANES; l++) begin
            va[l*WIDTH +: WIDTH] = 32'hFFFF_FFFF;
            vb[l*WIDTH +: WIDTH] = WIDTH'(l);
            e0[l*WIDTH +: WIDTH] = WIDTH'(l - 1);
        end
        tbl[3] = '{3'b000, 1'b0, 1, va, vb, e0, 1};
        for (int l = 0; l < LANES; l++) begin
            va[l*WIDTH +: WIDTH] = WIDTH'(32'h1_0000 + l);
            vb[l*WIDTH +: WIDTH] = 32'h1_0000;
            e0[l*WIDTH +: WIDTH] = WIDTH'(l << 16);
        end
        tbl[4] = '{3'b010, 1'b0, 0, va, vb, e0, MUL_LAT};
        for (int l = 0; l < LANES; l++) begin
            va[l*WIDTH +: WIDTH] = (l % 2 == 0) ? 32'h8000_0000 : 32'd5;
            vb[l*WIDTH +: WIDTH] = (l % 2 == 0) ? 32'h7FFF_FFFF : 32'hFFFF_FFFD;
            e0[l*WIDTH +: WIDTH] = (l % 2 == 0) ? 32'h8000_0000 : 32'd8;
        end
        tbl[5] = '{3'b001, 1'b1, 1, va, vb, e0, 1};

        for (int t = 0; t < 6; t++) begin
            drive(tbl[t].rid, tbl[t].op, tbl[t].vc, tbl[t].a, tbl[t].b);
            txn(tbl[t].rid, tbl[t].exp, tbl[t].lat, 0, 1'b0);
        end

        // Both requesters continuously valid; first response held 5 cycles.
        for (int l = 0; l < LANES; l++) begin
            va[l*WIDTH +: WIDTH] = WIDTH'(100 + l);
            vb[l*WIDTH +: WIDTH] = WIDTH'(103);
        end
        drive(0, 3'b000, 1'b0, va, vb);
        drive(1, 3'b001, 1'b0, va, vb);
        for (int k = 0; k < 4; k++) begin
            id = pick(1'b1, 1'b1);
            txn(id, ref_vec((id == 0) ? 3'b000 : 3'b001, 1'b0, va, vb), 1,
                (k == 0) ? 5 : 0, 1'b1);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            int pat;
            pat = $urandom_range(1, 3);
            op0 = 3'($urandom_range(0, 2)); op1 = 3'($urandom_range(0, 2));
            vc0 = 1'($urandom); vc1 = 1'($urandom);
            va = rand_vec(); vb = rand_vec();
            e1 = rand_vec(); e2 = rand_vec();
            if (pat[0]) drive(0, op0, vc0, va, vb);
            if (pat[1]) drive(1, op1, vc1, e1, e2);
            id = pick(pat[0], pat[1]);
            if (id == 0) txn(0, ref_vec(op0, vc0, va, vb), (op0 == 3'b010) ? MUL_LAT : 1,
                             $urandom_range(0, 2), 1'b0);
            else         txn(1, ref_vec(op1, vc1, e1, e2), (op1 == 3'b010) ? MUL_LAT : 1,
                             $urandom_range(0, 2), 1'b0);
        end

        // Reset in the middle of a multiply on requester 0.
        for (int l = 0; l < LANES; l++) begin
            va[l*WIDTH +: WIDTH] = WIDTH'(100 + l);
            vb[l*WIDTH +: WIDTH] = WIDTH'(103);
        end
        drive(0, 3'b010, 1'b0, va, vb);
        #1;
        check("rst_seq_grant0", DW'(req0_ready), DW'(1));
        @(posedge clk); #1;
        req0_valid = 1'b0;
        check("rst_seq_busy_exec", DW'(busy), DW'(1));
        #2 rst_n = 1'b0;
        last_model = 1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("midrst_busy", DW'(busy), '0);
        check("midrst_valid", DW'(resp_valid), '0);
        check("midrst_ready", DW'({req0_ready, req1_ready}), '0);
        check("midrst_id", DW'(resp_id), '0);
        check("midrst_data", resp_data, '0);
        @(posedge clk); #1;
        check("midrst_busy_edge", DW'(busy), '0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("discarded_no_resp", DW'(resp_valid), '0);
        end
        drive(0, 3'b000, 1'b0, va, vb);
        drive(1, 3'b001, 1'b1, va, vb);
        id = pick(1'b1, 1'b1);
        check("post_rst_pick0", DW'(id), '0);
        txn(id, ref_vec(3'b000, 1'b0, va, vb), 1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
